// File: rtl/snoopy_motion_pkg.sv
// Shared types and helpers for the Snoopy sprite motion controllers.
package snoopy_motion_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MOVE_NEG = 2'd1,
    S_MOVE_POS = 2'd2,
    S_BRAKE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_NEG  = 2'd1,
    REQ_POS  = 2'd2
  } req_e;

  // Signed velocity width able to hold +/-max_speed.
  function automatic int spd_width(input int max_speed);
    return $clog2(max_speed + 1) + 1;
  endfunction

endpackage

// File: rtl/snoopy_tick_divider.sv
// Divides frame ticks by DIV: step pulses on every DIV-th enabled tick after a clear.
module snoopy_tick_divider
  import snoopy_motion_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic step
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step = tick & (cnt_q == CNT_LAST);

endmodule

// File: rtl/snoopy_axis_motion_fsm.sv
// Single-axis ramped motion controller for the Snoopy sprite.
// Define SNOOPY_MOTION_WRAP_EN for wrap-around position instead of clamping.
module snoopy_axis_motion_fsm
  import snoopy_motion_pkg::*;
#(
  parameter int POS_W     = 8,
  parameter int MIN_POS   = 0,
  parameter int MAX_POS   = 152,
  parameter int START_POS = 76,
  parameter int MAX_SPEED = 3,
  parameter int ACCEL_DIV = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   frame_tick,
  input  logic                                   input_neg,
  input  logic                                   input_pos,
  output logic [POS_W-1:0]                       pos,
  output logic signed [spd_width(MAX_SPEED)-1:0] speed,
  output logic                                   moving,
  output logic                                   at_min,
  output logic                                   at_max
);

  localparam int SPD_W = spd_width(MAX_SPEED);
  localparam int EXT_W = POS_W + 2;
  localparam logic [POS_W-1:0]        MIN_P    = POS_W'(MIN_POS);
  localparam logic [POS_W-1:0]        MAX_P    = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0]        START_P  = POS_W'(START_POS);
  localparam logic signed [EXT_W-1:0] MIN_EXT  = EXT_W'(MIN_POS);
  localparam logic signed [EXT_W-1:0] MAX_EXT  = EXT_W'(MAX_POS);
  localparam logic signed [SPD_W-1:0] SPD_ZERO = SPD_W'(0);
  localparam logic signed [SPD_W-1:0] SPD_ONE  = SPD_W'(1);
  localparam logic signed [SPD_W-1:0] SPD_MAX  = SPD_W'(MAX_SPEED);
  localparam logic signed [SPD_W-1:0] SPD_NMAX = -SPD_MAX;

  state_e                   state_q, state_d;
  logic signed [SPD_W-1:0]  speed_q, speed_d;
  logic [POS_W-1:0]         pos_q, pos_d;
  req_e                     req;
  logic                     cnt_clr, step, spd_neg, block_neg, block_pos;
  logic signed [EXT_W-1:0]  pos_ext, spd_ext, sum_s;

  snoopy_tick_divider #(.DIV(ACCEL_DIV)) u_accel_div (
    .clock (clock),
    .reset (reset),
    .tick  (frame_tick),
    .clear (cnt_clr),
    .step  (step)
  );

  assign pos    = pos_q;
  assign speed  = speed_q;
  assign moving = (speed_q != SPD_ZERO);
  assign at_min = (pos_q == MIN_P);
  assign at_max = (pos_q == MAX_P);

`ifdef SNOOPY_MOTION_WRAP_EN
  assign block_neg = 1'b0;
  assign block_pos = 1'b0;
  logic signed [EXT_W-1:0] wrap_s;
  localparam logic signed [EXT_W-1:0] SPAN_EXT = EXT_W'(MAX_POS - MIN_POS + 1);
`else
  assign block_neg = at_min;
  assign block_pos = at_max;
`endif

  assign spd_neg = speed_q[SPD_W-1];
  assign pos_ext = {2'b00, pos_q};
  assign spd_ext = {{(EXT_W-SPD_W){speed_q[SPD_W-1]}}, speed_q};
  assign sum_s   = pos_ext + spd_ext;

  always_comb begin
    if (input_neg && !input_pos) begin
      req = REQ_NEG;
    end else if (input_pos && !input_neg) begin
      req = REQ_POS;
    end else begin
      req = REQ_NONE;
    end
  end

  // Next state, velocity ramp and position step; the bound check overrides the FSM.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    pos_d   = pos_q;
    cnt_clr = 1'b0;
`ifdef SNOOPY_MOTION_WRAP_EN
    wrap_s  = sum_s;
`endif
    if (frame_tick) begin
      case (state_q)
        S_IDLE: begin
          cnt_clr = 1'b1;
          if (req == REQ_NEG && !block_neg) begin
            state_d = S_MOVE_NEG;
            speed_d = -SPD_ONE;
          end else if (req == REQ_POS && !block_pos) begin
            state_d = S_MOVE_POS;
            speed_d = SPD_ONE;
          end else begin
            state_d = S_IDLE;
            speed_d = SPD_ZERO;
          end
        end
        S_MOVE_NEG: begin
          if (req != REQ_NEG) begin
            state_d = S_BRAKE;
            cnt_clr = 1'b1;
          end else if (step && speed_q != SPD_NMAX) begin
            speed_d = speed_q - SPD_ONE;
          end else begin
            speed_d = speed_q;
          end
        end
        S_MOVE_POS: begin
          if (req != REQ_POS) begin
            state_d = S_BRAKE;
            cnt_clr = 1'b1;
          end else if (step && speed_q != SPD_MAX) begin
            speed_d = speed_q + SPD_ONE;
          end else begin
            speed_d = speed_q;
          end
        end
        S_BRAKE: begin
          // Re-pressing the direction of travel resumes at the current speed.
          if ((req == REQ_NEG && spd_neg) || (req == REQ_POS && !spd_neg && speed_q != SPD_ZERO)) begin
            state_d = spd_neg ? S_MOVE_NEG : S_MOVE_POS;
            cnt_clr = 1'b1;
          end else if (speed_q == SPD_ZERO) begin
            state_d = S_IDLE;
          end else if (step) begin
            speed_d = spd_neg ? speed_q + SPD_ONE : speed_q - SPD_ONE;
            state_d = (speed_d == SPD_ZERO) ? S_IDLE : S_BRAKE;
          end else begin
            state_d = S_BRAKE;
          end
        end
        default: begin
          state_d = S_IDLE;
          speed_d = SPD_ZERO;
          cnt_clr = 1'b1;
        end
      endcase

`ifdef SNOOPY_MOTION_WRAP_EN
      if (sum_s > MAX_EXT) begin
        wrap_s = sum_s - SPAN_EXT;
      end else if (sum_s < MIN_EXT) begin
        wrap_s = sum_s + SPAN_EXT;
      end else begin
        wrap_s = sum_s;
      end
      pos_d = wrap_s[POS_W-1:0];
`else
      if (sum_s > MAX_EXT || sum_s < MIN_EXT) begin
        pos_d   = (sum_s > MAX_EXT) ? MAX_P : MIN_P;
        speed_d = SPD_ZERO;
        state_d = S_IDLE;
        cnt_clr = 1'b1;
      end else begin
        pos_d = sum_s[POS_W-1:0];
      end
`endif
    end else begin
      state_d = state_q;
      speed_d = speed_q;
      pos_d   = pos_q;
      cnt_clr = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      speed_q <= SPD_ZERO;
      pos_q   <= START_P;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      pos_q   <= pos_d;
    end
  end

endmodule

// File: tb/tb_snoopy_axis_motion_fsm.sv
// Scoreboard bench: two controller instances driven by directed and random stimulus,
// compared against an integer reference model of the motion rules.
module tb_snoopy_axis_motion_fsm;

`ifdef SNOOPY_MOTION_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {int minp; int maxp; int start; int maxs; int div;} prm_t;
  typedef struct {int pos; int spd; int mode; int cnt;} mdl_t;
  typedef struct {int pos; int spd;} exp_t;

  localparam prm_t PA = '{minp: 0,  maxp: 152, start: 76,  maxs: 3, div: 4};
  localparam prm_t PB = '{minp: 10, maxp: 152, start: 150, maxs: 2, div: 1};

  logic clock = 1'b0;
  logic reset = 1'b1, frame_tick = 1'b0, input_neg = 1'b0, input_pos = 1'b0;
  logic [7:0] pos_a, pos_b;
  logic signed [2:0] speed_a, speed_b;
  logic moving_a, moving_b, at_min_a, at_min_b, at_max_a, at_max_b;

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  mdl_t ma, mb;

  always #5 clock = ~clock;

  snoopy_axis_motion_fsm u_dut_a (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .input_neg(input_neg), .input_pos(input_pos),
    .pos(pos_a), .speed(speed_a), .moving(moving_a), .at_min(at_min_a), .at_max(at_max_a)
  );

  snoopy_axis_motion_fsm #(
    .POS_W(8), .MIN_POS(10), .MAX_POS(152), .START_POS(150), .MAX_SPEED(2), .ACCEL_DIV(1)
  ) u_dut_b (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .input_neg(input_neg), .input_pos(input_pos),
    .pos(pos_b), .speed(speed_b), .moving(moving_b), .at_min(at_min_b), .at_max(at_max_b)
  );

  function automatic mdl_t mreset(prm_t p);
    mdl_t r;
    r.pos = p.start; r.spd = 0; r.mode = 0; r.cnt = 0;
    return r;
  endfunction

  // mode: 0 = resting, 1 = driven by a held request, 2 = coasting down
  function automatic mdl_t mstep(mdl_t s, prm_t p, bit in_n, bit in_p);
    mdl_t n;
    int req, dir, np, span;
    n = s;
    req  = (in_n && !in_p) ? -1 : ((in_p && !in_n) ? 1 : 0);
    dir  = (s.spd > 0) ? 1 : ((s.spd < 0) ? -1 : 0);
    span = p.maxp - p.minp + 1;
    np   = s.pos + s.spd;
    case (s.mode)
      0: begin
        n.cnt = 0;
        if (req != 0 && (WRAP || !((req < 0 && s.pos == p.minp) || (req > 0 && s.pos == p.maxp)))) begin
          n.spd = req; n.mode = 1;
        end
      end
      1: begin
        if (req == dir) begin
          if (s.cnt == p.div - 1) begin
            n.cnt = 0;
            if (s.spd * dir < p.maxs) n.spd = s.spd + dir;
          end else n.cnt = s.cnt + 1;
        end else begin
          n.mode = 2; n.cnt = 0;
        end
      end
      default: begin
        if (req != 0 && req == dir) begin
          n.mode = 1; n.cnt = 0;
        end else if (s.cnt == p.div - 1) begin
          n.cnt = 0; n.spd = s.spd - dir;
          if (n.spd == 0) n.mode = 0;
        end else n.cnt = s.cnt + 1;
      end
    endcase
    if (WRAP) begin
      if (np > p.maxp) np = np - span;
      else if (np < p.minp) np = np + span;
      n.pos = np;
    end else if (np > p.maxp || np < p.minp) begin
      n.pos = (np > p.maxp) ? p.maxp : p.minp;
      n.spd = 0; n.mode = 0; n.cnt = 0;
    end else begin
      n.pos = np;
    end
    return n;
  endfunction

  task automatic drive(bit rst, bit tk, bit n, bit p);
    exp_t e;
    @(negedge clock);
    reset = rst; frame_tick = tk; input_neg = n; input_pos = p;
    if (rst) begin
      ma = mreset(PA); mb = mreset(PB);
    end else if (tk) begin
      ma = mstep(ma, PA, n, p); mb = mstep(mb, PB, n, p);
    end
    e.pos = ma.pos; e.spd = ma.spd; qa.push_back(e);
    e.pos = mb.pos; e.spd = mb.spd; qb.push_back(e);
  endtask

  task automatic ticks(int cnt, bit n, bit p);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 1)) drive(1'b0, 1'b0, n, p);
      drive(1'b0, 1'b1, n, p);
    end
  endtask

  task automatic cmp(string tag, string fld, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s.%s at %0t: got %0d expected %0d", tag, fld, $time, got, want);
    end
  endtask

  task automatic check_dut(string tag, exp_t e, prm_t p, int dpos, int dspd, bit mv, bit amin, bit amax);
    cmp(tag, "pos", dpos, e.pos);
    cmp(tag, "speed", dspd, e.spd);
    cmp(tag, "moving", int'(mv), int'(e.spd != 0));
    cmp(tag, "at_min", int'(amin), int'(e.pos == p.minp));
    cmp(tag, "at_max", int'(amax), int'(e.pos == p.maxp));
  endtask

  // Monitor: after every active edge, pop the prediction for that edge and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_dut("A", e, PA, int'(pos_a), int'(speed_a), moving_a, at_min_a, at_max_a);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_dut("B", e, PB, int'(pos_b), int'(speed_b), moving_b, at_min_b, at_max_b);
      end
    end
  end

  initial begin
    bit rn, rp, rst, tk;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    ticks(12, 1'b0, 1'b1);          // ramp up, B runs into its upper bound
    ticks(16, 1'b0, 1'b0);          // brake down to rest
    ticks(2, 1'b0, 1'b1);
    ticks(3, 1'b0, 1'b1);           // reach speed +2
    ticks(14, 1'b1, 1'b1);          // both pressed: brake without reversal
    ticks(6, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);  // reset wins over a tick mid-motion
    ticks(3, 1'b1, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    ticks(70, 1'b1, 1'b0);          // run into the lower bound and keep pushing
    ticks(80, 1'b0, 1'b1);          // reverse through zero toward the upper bound
    rn = 1'b0; rp = 1'b0;
    repeat (900) begin
      rst = ($urandom_range(0, 299) == 0);
      tk  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 11) == 0) begin
        rn = 1'($urandom_range(0, 1));
        rp = 1'($urandom_range(0, 1));
      end
      drive(rst, tk, rn, rp);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clock);
    #2;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d predictions left unchecked, expected 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
